// File: rtl/wb_pkg.sv
// Shared Wishbone widths, slave FSM states and the byte-lane merge helper.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    // Lanes with sel=1 take the new byte; the rest keep the old one.
    function automatic logic [WB_DATA_W-1:0] wb_byte_merge(
        input logic [WB_DATA_W-1:0] old_w,
        input logic [WB_DATA_W-1:0] new_w,
        input logic [WB_SEL_W-1:0]  sel
    );
        logic [WB_DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < WB_SEL_W; i++) begin
            if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_ram_core.sv
// Word-organised RAM: synchronous read (read-first) and byte-enable write.
module wb_ram_core
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [WB_SEL_W-1:0]   sel,
  input  logic [WB_DATA_W-1:0]  wdata,
  output logic [WB_DATA_W-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WB_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wb_byte_merge(mem[idx], wdata, sel);
    rdata <= mem[idx];
  end

endmodule

// File: rtl/wb_slave_ram.sv
// Wishbone B4 classic slave memory with programmable wait states and ERR on bad addresses.
module wb_slave_ram
    import wb_pkg::*;
#(
    parameter int                   ADDR_WIDTH  = 10,
    parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                   WAIT_STATES = 1,
    parameter                       INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [WB_ADDR_W-1:0] wb_adr_i,
    input  logic [WB_DATA_W-1:0] wb_dat_i,
    input  logic [WB_SEL_W-1:0]  wb_sel_i,
    output logic [WB_DATA_W-1:0] wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o
);

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic                  we_q, valid_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [WB_DATA_W-1:0]  dat_q;
    logic [WB_SEL_W-1:0]   sel_q;
    logic                  ack_q, err_q, rd_q;

    logic [WB_ADDR_W-1:0]  off;
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_idx;

    logic                  latch, enter_resp;
    logic                  cur_we, cur_valid;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [WB_DATA_W-1:0]  cur_dat;
    logic [WB_SEL_W-1:0]   cur_sel;
    logic                  ram_we;
    logic [WB_DATA_W-1:0]  ram_rdata;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    assign off       = wb_adr_i - BASE_ADDR;
    assign req_valid = ((off >> (ADDR_WIDTH + 2)) == '0) && (wb_adr_i[1:0] == 2'b00);
    assign req_idx   = off[ADDR_WIDTH+1:2];

    // With zero wait states RESP is entered straight from IDLE, so the live bus is used.
    always_comb begin
        cur_we    = we_q;
        cur_valid = valid_q;
        cur_idx   = idx_q;
        cur_dat   = dat_q;
        cur_sel   = sel_q;
        if (state_q == IDLE) begin
            cur_we    = wb_we_i;
            cur_valid = req_valid;
            cur_idx   = req_idx;
            cur_dat   = wb_dat_i;
            cur_sel   = wb_sel_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch      = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                we_q    <= wb_we_i;
                valid_q <= req_valid;
                idx_q   <= req_idx;
                dat_q   <= wb_dat_i;
                sel_q   <= wb_sel_i;
            end
            ack_q <= enter_resp && cur_valid;
            err_q <= enter_resp && !cur_valid;
            rd_q  <= enter_resp && cur_valid && !cur_we;
        end
    end

    assign ram_we = enter_resp && cur_valid && cur_we && !reset;

    wb_ram_core #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .idx  (cur_idx),
        .sel  (cur_sel),
        .wdata(cur_dat),
        .rdata(ram_rdata)
    );

    assign wb_dat_o = rd_q ? ram_rdata : '0;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_slave_ram.sv
// Bench for wb_slave_ram: three instances (W=1, W=3, W=0 at high base) against a byte-level memory model.
module tb_wb_slave_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cyc;
    logic        stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [2:0]  ack, err;
    logic [31:0] dat_o [3];

    int compared   = 0;
    int mismatched = 0;
    int          wlat [3];
    logic [31:0] base [3];
    logic [7:0]  mb [int];

    localparam int DEPTH_B = 4 * 1024;

    always #5 clk = ~clk;

    wb_slave_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_a (
        .clk(clk), .reset(reset), .wb_cyc_i(cyc[0]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_dat_o(dat_o[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]));

    wb_slave_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_b (
        .clk(clk), .reset(reset), .wb_cyc_i(cyc[1]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_dat_o(dat_o[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]));

    wb_slave_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(0)) u_c (
        .clk(clk), .reset(reset), .wb_cyc_i(cyc[2]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_dat_o(dat_o[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory as a byte map keyed by instance and byte offset; addresses decoded arithmetically.
    function automatic void model(input int inst, input bit w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] s,
                                  output bit ok, output logic [31:0] rd);
        logic [31:0] o;
        int key;
        o  = a - base[inst];
        ok = (o < DEPTH_B) && (a % 4 == 0);
        rd = '0;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                key = inst * 8192 + int'(o) + i;
                if (w && s[i]) mb[key] = d[8*i +: 8];
                else if (!w) rd[8*i +: 8] = mb.exists(key) ? mb[key] : 8'hxx;
            end
        end
    endfunction

    task automatic xfer(input string tag, input int inst, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        bit ok, got;
        logic [31:0] exp_rd;
        int k;
        model(inst, w, a, d, s, ok, exp_rd);
        @(negedge clk);
        cyc[inst] = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        k = 0; got = 1'b0;
        while (!got && k <= 40) begin
            @(negedge clk);
            if (ack[inst] || err[inst]) got = 1'b1;
            else k++;
        end
        check({tag, ".latency"}, 32'(k), 32'(wlat[inst]));
        check({tag, ".ack"}, 32'(ack[inst]), 32'(ok));
        check({tag, ".err"}, 32'(err[inst]), 32'(!ok));
        if (!w || !ok) check({tag, ".dat"}, dat_o[inst], exp_rd);
        cyc[inst] = 1'b0; stb = 1'b0;
        @(negedge clk);
        check({tag, ".drop"}, {ack[inst], err[inst], dat_o[inst]}, 34'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [31:0] e, a;
        int inst;
        wlat = '{1, 3, 0};
        base = '{32'h0, 32'h0, 32'h8000_0000};
        cyc = '0; stb = 0; we = 0; adr = '0; wdat = '0; sel = '0;

        // Reset with a request pending on every instance.
        reset = 1'b1; cyc = 3'b111; stb = 1'b1; adr = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset.ack", 32'(ack), 32'h0);
            check("reset.err", 32'(err), 32'h0);
            check("reset.dat", dat_o[0] | dat_o[1] | dat_o[2], 32'h0);
        end
        reset = 1'b0; cyc = '0; stb = 1'b0;

        xfer("w1.wr", 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        xfer("w1.rd", 0, 0, 32'h10, 32'h0, 4'hF);

        xfer("lane.wr0", 0, 1, 32'h20, 32'h1122_3344, 4'hF);
        xfer("lane.wr1", 0, 1, 32'h20, 32'hAABB_CCDD, 4'b0101);
        xfer("lane.rd", 0, 0, 32'h20, 32'h0, 4'hF);
        xfer("lane.sel0", 0, 1, 32'h20, 32'h5555_5555, 4'b0000);
        xfer("lane.rd2", 0, 0, 32'h20, 32'h0, 4'hF);

        xfer("err.range", 0, 0, 32'h4000, 32'h0, 4'hF);
        xfer("err.top", 0, 0, 32'h0FFC, 32'h0, 4'hF);
        xfer("err.pre", 0, 1, 32'h4, 32'hCAFE_F00D, 4'hF);
        xfer("err.misal", 0, 1, 32'h6, 32'h0BAD_0BAD, 4'hF);
        xfer("err.chk", 0, 0, 32'h4, 32'h0, 4'hF);

        // Abort on the W=3 instance: cyc dropped after one cycle in WAIT.
        xfer("abort.pre", 1, 1, 32'h20, 32'h1234_5678, 4'hF);
        @(negedge clk);
        cyc[1] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; wdat = 32'hFFFF_0000; sel = 4'hF;
        @(negedge clk);
        @(negedge clk);
        cyc[1] = 1'b0; stb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort.quiet", {30'h0, ack[1], err[1]}, 32'h0);
        end
        xfer("abort.rd", 1, 0, 32'h20, 32'h0, 4'hF);

        // Reset during WAIT discards the write.
        @(negedge clk);
        cyc[1] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; wdat = 32'h0F0F_0F0F; sel = 4'hF;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; cyc[1] = 1'b0; stb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstmid.quiet", {30'h0, ack[1], err[1]}, 32'h0);
        end
        xfer("rstmid.rd", 1, 0, 32'h20, 32'h0, 4'hF);

        // W=0 at BASE 0x8000_0000: back-to-back reads with stb held.
        for (int j = 0; j < 4; j++)
            xfer("b2b.wr", 2, 1, 32'h8000_0000 + 32'(4 * j), $urandom, 4'hF);
        @(negedge clk);
        cyc[2] = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h8000_0000;
        for (int j = 0; j < 4; j++) begin
            model(2, 0, adr, 32'h0, 4'hF, ok, e);
            @(negedge clk);
            check("b2b.ack", 32'(ack[2]), 32'h1);
            check("b2b.dat", dat_o[2], e);
            if (j == 3) begin cyc[2] = 1'b0; stb = 1'b0; end
            else adr = adr + 32'h4;
            @(negedge clk);
            check("b2b.gap", {30'h0, ack[2], err[2]}, 32'h0);
        end
        xfer("base.below", 2, 0, 32'h7FFF_FFFC, 32'h0, 4'hF);

        // Randomized traffic against the model over a small pre-initialised window.
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 8; j++)
                xfer("rnd.init", i, 1, base[i] + 32'h100 + 32'(4 * j), $urandom, 4'hF);
        for (int n = 0; n < 60; n++) begin
            inst = int'($urandom_range(0, 2));
            a = base[inst] + 32'h100 + 32'(4 * $urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0: a = a + 32'(1 + $urandom_range(0, 2));
                1: a = a + 32'h1000;
                2: a = base[inst] - 32'(4 * (1 + $urandom_range(0, 3)));
                default: ;
            endcase
            xfer("rnd", inst, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
